// File: rtl/fft_frame_capture.sv
// rtl/fft_frame_capture.sv - FFT output capture into a banked result RAM
// Frame-length checking, host bank release, overflow dropping and status counters.
module fft_frame_capture #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATAIN_WIDTH = 29,
  parameter int LANE_WIDTH   = 32,
  parameter int BANK_BITS    = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                            CLK,
  input  logic                            RSTn,
  input  logic                            sop,
  input  logic                            eop,
  input  logic                            valid,
  input  logic [DATAIN_WIDTH-1:0]         datain_re,
  input  logic [DATAIN_WIDTH-1:0]         datain_im,
  input  logic [ADDR_WIDTH:0]             frame_len,
  input  logic                            bank_rel,
  input  logic [BANK_BITS-1:0]            bank_rel_idx,
  output logic [BANK_BITS+ADDR_WIDTH-1:0] addr,
  output logic [2*LANE_WIDTH-1:0]         dataout,
  output logic                            wren,
  output logic                            frame_done,
  output logic [BANK_BITS-1:0]            done_bank,
  output logic                            frame_err,
  output logic [1:0]                      err_code,
  output logic [(1<<BANK_BITS)-1:0]       bank_full,
  output logic [CNT_WIDTH-1:0]            frame_cnt,
  output logic [CNT_WIDTH-1:0]            drop_cnt
);

  localparam int NB = 1 << BANK_BITS;
  localparam int IW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_CAPT, S_DROP} state_t;

  state_t                         r_state, w_state_nxt;
  logic [BANK_BITS-1:0]           r_wp;
  logic [IW-1:0]                  r_idx, r_len;
  logic [BANK_BITS+ADDR_WIDTH-1:0] r_addr;
  logic [2*LANE_WIDTH-1:0]        r_dataout;
  logic                           r_wren, r_frame_done, r_frame_err;
  logic [BANK_BITS-1:0]           r_done_bank;
  logic [1:0]                     r_err_code;
  logic [NB-1:0]                  r_bank_full, w_bank_full_nxt;
  logic [CNT_WIDTH-1:0]           r_frame_cnt, r_drop_cnt;

  logic [IW-1:0]         w_len_in, w_len, w_cnt, w_wr_idx;
  logic [LANE_WIDTH-1:0] w_re_ext, w_im_ext;
  logic                  w_start, w_drop_new, w_cont, w_long, w_wr;
  logic                  w_good, w_short, w_err;
  logic [1:0]            w_code;

  assign w_len_in = (frame_len == '0) ? (IW'(1) << ADDR_WIDTH) : frame_len;
  assign w_re_ext = LANE_WIDTH'($signed(datain_re));
  assign w_im_ext = LANE_WIDTH'($signed(datain_im));

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (valid) begin
      case (r_state)
        S_IDLE: if (sop) w_state_nxt = r_bank_full[r_wp] ? S_DROP : (eop ? S_IDLE : S_CAPT);
        S_CAPT: begin
          if (eop)                        w_state_nxt = S_IDLE;
          else if (!sop && r_idx == r_len) w_state_nxt = S_DROP;
        end
        S_DROP: begin
          if (eop)      w_state_nxt = S_IDLE;
          else if (sop) w_state_nxt = r_bank_full[r_wp] ? S_DROP : S_CAPT;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // A sop seen in DROP without eop behaves exactly like a sop seen in IDLE.
  always_comb begin
    w_start    = 1'b0;
    w_drop_new = 1'b0;
    w_cont     = 1'b0;
    w_long     = 1'b0;
    if (valid) begin
      case (r_state)
        S_IDLE, S_DROP: if (sop && (r_state == S_IDLE || !eop)) begin
          w_start    = !r_bank_full[r_wp];
          w_drop_new = r_bank_full[r_wp];
        end
        S_CAPT: begin
          w_start = sop;
          w_cont  = !sop && (r_idx != r_len);
          w_long  = !sop && (r_idx == r_len);
        end
        default: ;
      endcase
    end
    w_wr     = w_start | w_cont;
    w_wr_idx = w_start ? '0 : r_idx;
    w_cnt    = w_start ? IW'(1) : r_idx + IW'(1);
    w_len    = w_start ? w_len_in : r_len;
    w_good   = w_wr && eop && (w_cnt == w_len);
    w_short  = w_wr && eop && (w_cnt != w_len);
    w_err    = w_long | w_short | (w_start && r_state == S_CAPT);
    if (w_start && r_state == S_CAPT) w_code = 2'b11;
    else if (w_long)                  w_code = 2'b10;
    else                              w_code = 2'b01;
  end

  // Release is applied before the new frame's set so a finishing frame always wins.
  always_comb begin
    w_bank_full_nxt = r_bank_full;
    if (bank_rel) w_bank_full_nxt[bank_rel_idx] = 1'b0;
    if (w_good)   w_bank_full_nxt[r_wp] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_wp         <= '0;
      r_idx        <= '0;
      r_len        <= '0;
      r_addr       <= '0;
      r_dataout    <= '0;
      r_wren       <= 1'b0;
      r_frame_done <= 1'b0;
      r_done_bank  <= '0;
      r_frame_err  <= 1'b0;
      r_err_code   <= 2'b00;
      r_bank_full  <= '0;
      r_frame_cnt  <= '0;
      r_drop_cnt   <= '0;
    end else begin
      r_wren       <= w_wr;
      r_frame_done <= w_good;
      r_frame_err  <= w_err;
      r_bank_full  <= w_bank_full_nxt;
      if (w_wr) begin
        r_addr    <= {r_wp, w_wr_idx[ADDR_WIDTH-1:0]};
        r_dataout <= {w_re_ext, w_im_ext};
        r_idx     <= w_cnt;
      end
      if (w_start) r_len <= w_len_in;
      if (w_err)   r_err_code <= w_code;
      if (w_good) begin
        r_done_bank <= r_wp;
        r_wp        <= r_wp + BANK_BITS'(1);
        r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
      end
      if (w_drop_new) r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
    end
  end

  assign addr       = r_addr;
  assign dataout    = r_dataout;
  assign wren       = r_wren;
  assign frame_done = r_frame_done;
  assign done_bank  = r_done_bank;
  assign frame_err  = r_frame_err;
  assign err_code   = r_err_code;
  assign bank_full  = r_bank_full;
  assign frame_cnt  = r_frame_cnt;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_fft_frame_capture.sv
// tb/tb_fft_frame_capture.sv - directed self-checking bench for fft_frame_capture
module tb_fft_frame_capture;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        sop, eop, valid;
  logic [28:0] datain_re, datain_im;
  logic [10:0] frame_len;
  logic        bank_rel;
  logic [0:0]  bank_rel_idx;
  logic [10:0] addr;
  logic [63:0] dataout;
  logic        wren, frame_done, frame_err;
  logic [0:0]  done_bank;
  logic [1:0]  err_code;
  logic [1:0]  bank_full;
  logic [15:0] frame_cnt, drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  fft_frame_capture dut (
    .CLK(CLK), .RSTn(RSTn), .sop(sop), .eop(eop), .valid(valid),
    .datain_re(datain_re), .datain_im(datain_im), .frame_len(frame_len),
    .bank_rel(bank_rel), .bank_rel_idx(bank_rel_idx),
    .addr(addr), .dataout(dataout), .wren(wren), .frame_done(frame_done),
    .done_bank(done_bank), .frame_err(frame_err), .err_code(err_code),
    .bank_full(bank_full), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic s, input logic e, input logic v,
                      input logic [28:0] re, input logic [28:0] im);
    sop = s; eop = e; valid = v; datain_re = re; datain_im = im;
    @(posedge CLK); #1;
    sop = 1'b0; eop = 1'b0; valid = 1'b0; bank_rel = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 1'b0, 1'b0, 29'd0, 29'd0);
  endtask

  task automatic wbeat(input string tag, input logic s, input logic e, input int k,
                       input logic exp_wr, input logic [10:0] exp_addr);
    step(s, e, 1'b1, 29'(k), 29'(k + 256));
    check({tag, " wren"}, 64'(wren), 64'(exp_wr));
    if (exp_wr) begin
      check({tag, " addr"}, 64'(addr), 64'(exp_addr));
      check({tag, " data"}, dataout, {32'(k), 32'(k + 256)});
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " addr"}, 64'(addr), 64'd0);
    check({tag, " data"}, dataout, 64'd0);
    check({tag, " wren"}, 64'(wren), 64'd0);
    check({tag, " done"}, 64'(frame_done), 64'd0);
    check({tag, " done_bank"}, 64'(done_bank), 64'd0);
    check({tag, " err"}, 64'(frame_err), 64'd0);
    check({tag, " code"}, 64'(err_code), 64'd0);
    check({tag, " full"}, 64'(bank_full), 64'd0);
    check({tag, " fcnt"}, 64'(frame_cnt), 64'd0);
    check({tag, " dcnt"}, 64'(drop_cnt), 64'd0);
  endtask

  initial begin
    RSTn = 1'b0; sop = 1'b0; eop = 1'b0; valid = 1'b0;
    datain_re = '0; datain_im = '0; frame_len = 11'd8;
    bank_rel = 1'b0; bank_rel_idx = '0;
    repeat (2) @(posedge CLK);
    #1;
    check_zero("reset");
    RSTn = 1'b1;
    idle(1);

    for (int i = 0; i < 8; i++) wbeat("A", i == 0, i == 7, i, 1'b1, 11'(i));
    check("A done", 64'(frame_done), 64'd1);
    check("A done_bank", 64'(done_bank), 64'd0);
    check("A full", 64'(bank_full), 64'b01);
    check("A fcnt", 64'(frame_cnt), 64'd1);
    idle(1);
    check("A done pulse", 64'(frame_done), 64'd0);
    check("A idle wren", 64'(wren), 64'd0);

    for (int i = 0; i < 8; i++) wbeat("B", i == 0, i == 7, i, 1'b1, 11'h400 + 11'(i));
    check("B done", 64'(frame_done), 64'd1);
    check("B done_bank", 64'(done_bank), 64'd1);
    check("B full", 64'(bank_full), 64'b11);
    check("B fcnt", 64'(frame_cnt), 64'd2);

    for (int i = 0; i < 8; i++) wbeat("C", i == 0, i == 7, i, 1'b0, 11'd0);
    check("C dcnt", 64'(drop_cnt), 64'd1);
    check("C fcnt", 64'(frame_cnt), 64'd2);
    check("C done", 64'(frame_done), 64'd0);

    bank_rel = 1'b1; bank_rel_idx = 1'b0;
    idle(1);
    check("rel0 full", 64'(bank_full), 64'b10);

    for (int i = 0; i < 8; i++) wbeat("D", i == 0, i == 7, i, 1'b1, 11'(i));
    check("D done", 64'(frame_done), 64'd1);
    check("D done_bank", 64'(done_bank), 64'd0);
    check("D full", 64'(bank_full), 64'b11);
    check("D fcnt", 64'(frame_cnt), 64'd3);

    // release of the write bank in the same cycle as sop: the frame is still dropped
    bank_rel = 1'b1; bank_rel_idx = 1'b1;
    wbeat("E", 1'b1, 1'b0, 0, 1'b0, 11'd0);
    check("E dcnt", 64'(drop_cnt), 64'd2);
    check("E full", 64'(bank_full), 64'b01);
    for (int i = 1; i < 8; i++) wbeat("E", 1'b0, i == 7, i, 1'b0, 11'd0);
    check("E done", 64'(frame_done), 64'd0);
    bank_rel = 1'b1; bank_rel_idx = 1'b0;
    idle(1);
    check("rel both full", 64'(bank_full), 64'b00);

    for (int i = 0; i < 5; i++) wbeat("S", i == 0, i == 4, i, 1'b1, 11'h400 + 11'(i));
    check("S err", 64'(frame_err), 64'd1);
    check("S code", 64'(err_code), 64'd1);
    check("S done", 64'(frame_done), 64'd0);
    check("S full", 64'(bank_full), 64'b00);
    idle(1);
    check("S err pulse", 64'(frame_err), 64'd0);

    for (int i = 0; i < 8; i++) wbeat("L", i == 0, 1'b0, i, 1'b1, 11'h400 + 11'(i));
    wbeat("L9", 1'b0, 1'b0, 8, 1'b0, 11'd0);
    check("L9 err", 64'(frame_err), 64'd1);
    check("L9 code", 64'(err_code), 64'd2);
    wbeat("L10", 1'b0, 1'b1, 9, 1'b0, 11'd0);
    check("L10 err", 64'(frame_err), 64'd0);
    check("L fcnt", 64'(frame_cnt), 64'd3);

    for (int i = 0; i < 3; i++) wbeat("R", i == 0, 1'b0, i, 1'b1, 11'h400 + 11'(i));
    step(1'b1, 1'b0, 1'b1, 29'h1FFFFFFF, 29'd5);
    check("R4 wren", 64'(wren), 64'd1);
    check("R4 addr", 64'(addr), 64'h400);
    check("R4 data", dataout, 64'hFFFFFFFF_00000005);
    check("R4 err", 64'(frame_err), 64'd1);
    check("R4 code", 64'(err_code), 64'd3);
    for (int i = 1; i < 8; i++) wbeat("R", 1'b0, i == 7, i, 1'b1, 11'h400 + 11'(i));
    check("R done", 64'(frame_done), 64'd1);
    check("R done_bank", 64'(done_bank), 64'd1);
    check("R full", 64'(bank_full), 64'b10);
    check("R fcnt", 64'(frame_cnt), 64'd4);

    wbeat("G", 1'b1, 1'b0, 0, 1'b1, 11'd0);
    idle(1);
    check("G gap wren", 64'(wren), 64'd0);
    wbeat("G", 1'b0, 1'b0, 1, 1'b1, 11'd1);
    step(1'b1, 1'b1, 1'b0, 29'd7, 29'd7);
    check("G gap sop wren", 64'(wren), 64'd0);
    wbeat("G", 1'b0, 1'b0, 2, 1'b1, 11'd2);
    @(negedge CLK);
    RSTn = 1'b0;
    #1;
    check_zero("midreset");
    idle(1);
    RSTn = 1'b1;
    idle(1);

    for (int i = 0; i < 8; i++) wbeat("P", i == 0, i == 7, i + 20, 1'b1, 11'(i));
    check("P done_bank", 64'(done_bank), 64'd0);
    check("P fcnt", 64'(frame_cnt), 64'd1);
    check("P full", 64'(bank_full), 64'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
